// File: rtl/acc_sequencer_pkg.sv
// Shared definitions for the accumulator sequencer: ALU opcodes, FSM states,
// next-pc selects and instruction field layout.
package acc_sequencer_pkg;

    typedef enum logic [3:0] {
        kADD = 4'd0,  kSUB = 4'd1,  kAND = 4'd2,  kXOR = 4'd3,
        kSHL = 4'd4,  kSHR = 4'd5,  kNOT = 4'd6,  kLDI = 4'd7,
        kJMP = 4'd8,  kBRZ = 4'd9,  kBRN = 4'd10, kMLD = 4'd11,
        kMST = 4'd12, kLDR = 4'd13, kSTR = 4'd14, kCLR = 4'd15
    } op_mne;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

    typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_OFF, PC_CLR} pc_sel_t;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 5;
    localparam int OPD_W   = 5;

    localparam logic [7:0] REG_BASE_DEF = 8'hE0;
    localparam int         MAX_WAIT_DEF = 15;

    function automatic logic op_is_read(op_mne op);
        return (op == kMLD) || (op == kLDR);
    endfunction

    // LDR/STR address the register window above REG_BASE.
    function automatic logic op_is_reg_window(op_mne op);
        return (op == kLDR) || (op == kSTR);
    endfunction

endpackage

// File: rtl/acc_sequencer_seq_pc.sv
// Program counter for the sequencer: hold, increment, relative jump or clear,
// all modulo 2^PC_W.
module acc_sequencer_seq_pc
    import acc_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      sel_i,
    input  logic [PC_W-1:0] off_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel_t'(sel_i))
            PC_INC:  pc_d = pc_q + PC_W'(1);
            PC_OFF:  pc_d = pc_q + off_i;
            PC_CLR:  pc_d = '0;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/execute controller for the 8-bit accumulator ALU: owns pc, ir, acc and
// flags, drives the combinational ALU and sequences data-memory handshakes.
module acc_sequencer
    import acc_sequencer_pkg::*;
#(
    parameter int         PC_W     = 8,
    parameter logic [7:0] REG_BASE = REG_BASE_DEF,
    parameter int         MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [8:0]      instr_in,
    output logic            dm_req,
    output logic            dm_we,
    output logic [7:0]      dm_addr,
    output logic [7:0]      dm_wdata,
    input  logic [7:0]      dm_rdata,
    input  logic            dm_ack,
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_in_a,
    output logic [7:0]      alu_in_acc,
    output logic            alu_ci,
    input  logic [7:0]      alu_acc,
    input  logic            alu_co,
    input  logic            alu_z,
    input  logic            alu_neg,
    output logic [7:0]      acc_q,
    output logic [2:0]      flags_q,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [8:0]        ir_q, ir_d;
    logic [7:0]        accum_q, accum_d;
    logic [2:0]        flg_q, flg_d;      // {co, z, neg}
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    pc_sel_t           pc_sel;
    logic [PC_W-1:0]   pc;

    op_mne             op;
    logic [7:0]        imm8;
    logic [PC_W-1:0]   off;
    logic              off_zero;

    assign op       = op_mne'(ir_q[OPC_MSB:OPC_LSB]);
    assign imm8     = {{(8 - OPD_W){1'b0}}, ir_q[OPD_W-1:0]};
    assign off      = {{(PC_W - OPD_W){ir_q[OPD_W-1]}}, ir_q[OPD_W-1:0]};
    assign off_zero = (ir_q[OPD_W-1:0] == '0);

    acc_sequencer_seq_pc #(
        .PC_W (PC_W)
    ) u_seq_pc (
        .clk_i (CLK),
        .rst_i (reset),
        .sel_i (pc_sel),
        .off_i (off),
        .pc_o  (pc)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        accum_d  = accum_q;
        flg_d    = flg_q;
        wait_d   = wait_q;
        err_d    = err_q;
        pc_sel   = PC_HOLD;
        alu_op   = kCLR;
        alu_in_a = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                alu_op   = op;
                alu_in_a = imm8;
                state_d  = FETCH;
                case (op)
                    kADD, kSUB, kAND, kXOR, kSHL, kSHR, kNOT, kLDI: begin
                        accum_d = alu_acc;
                        flg_d   = {alu_co, alu_z, alu_neg};
                        pc_sel  = PC_INC;
                    end
                    kCLR: begin
                        flg_d  = '0;
                        pc_sel = PC_INC;
                    end
                    kJMP: begin
                        // A zero-offset jump is the program's halt instruction.
                        if (off_zero) begin
                            state_d = HALT;
                        end else begin
                            pc_sel = PC_OFF;
                        end
                    end
                    kBRZ:    pc_sel = flg_q[1] ? PC_OFF : PC_INC;
                    kBRN:    pc_sel = flg_q[0] ? PC_OFF : PC_INC;
                    default: begin
                        state_d = MEM;
                        wait_d  = '0;
                    end
                endcase
            end

            MEM: begin
                dm_req   = 1'b1;
                dm_we    = !op_is_read(op);
                dm_addr  = op_is_reg_window(op) ? (REG_BASE + imm8) : imm8;
                alu_op   = op;
                alu_in_a = dm_rdata;
                // An ack on the final allowed cycle still completes the access.
                if (dm_ack) begin
                    if (op_is_read(op)) begin
                        accum_d  = alu_acc;
                        flg_d[1] = alu_z;
                    end
                    pc_sel  = PC_INC;
                    state_d = FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            HALT: begin
                if (start) begin
                    pc_sel  = PC_CLR;
                    state_d = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
            accum_q <= '0;
            flg_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            accum_q <= accum_d;
            flg_q   <= flg_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign instr_addr = pc;
    assign dm_wdata   = accum_q;
    assign alu_in_acc = accum_q;
    assign alu_ci     = flg_q[2];
    assign acc_q      = accum_q;
    assign flags_q    = flg_q;
    assign busy       = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);
    assign done       = (state_q == HALT);
    assign err        = err_q;

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 8-bit accumulator ALU; the ALU itself stays purely combinational.
- Owns the PC, the instruction register, the accumulator register and the flag registers (co, z, neg).
- Fetches 9-bit instructions from the instruction ROM, drives the ALU opcode and operands, and sequences data-memory handshakes and branches.
- Sits between instr_rom, data_mem and alu in the top level.

Parameters:
- PC_W, 8, program counter / instruction address width.
- REG_BASE, 8'hE0, data-memory base address for LDR/STR register-window accesses.
- MAX_WAIT, 15, dm_ack timeout in cycles; on expiry the block sets err and halts.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE.
- instr_addr  out  PC_W  ROM address (= pc).
- instr_valid  in  1  ROM data valid this cycle.
- instr_in  in  9  instruction: [8:5] opcode (op_mne), [4:0] operand.
- dm_req  out  1  data-memory request, held until ack.
- dm_we  out  1  1 = write, 0 = read; valid while dm_req is high.
- dm_addr  out  8  data-memory address.
- dm_wdata  out  8  write data (= acc).
- dm_rdata  in  8  read data, valid with dm_ack.
- dm_ack  in  1  one-cycle completion strobe.
- alu_op  out  4  ALU opcode.
- alu_in_a  out  8  ALU operand A.
- alu_in_acc  out  8  ALU accumulator input (= acc register).
- alu_ci  out  1  carry in (= co flag register).
- alu_acc  in  8  ALU result.
- alu_co  in  1  ALU carry flag.
- alu_z  in  1  ALU zero flag.
- alu_neg  in  1  ALU negative flag.
- acc_q  out  8  architectural accumulator.
- flags_q  out  3  {co, z, neg} registers.
- busy  out  1  high in every state except IDLE and HALT.
- done  out  1  high in HALT.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async): state=IDLE; pc, ir, acc, flags = 0; dm_req=0, dm_we=0, busy=0, done=0, err=0. An active reset drops dm_req immediately, mid-transaction included. alu_op=kCLR whenever the state is not EXEC or MEM.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE -> FETCH on start. start is ignored in every other state. HALT -> FETCH on start, with pc reset to 0 and acc/flags kept.
- FETCH: instr_addr=pc. When instr_valid=1, latch ir=instr_in and go to EXEC. Otherwise stay in FETCH; there is no timeout.
- EXEC, one cycle, combinational ALU. Operand rules:
  - imm = zero-extended ir[4:0]; off = sign-extended ir[4:0].
  - ADD, SUB, AND, XOR, SHL, SHR, NOT, LDI: alu_in_a=imm. At the clock edge, acc<=alu_acc, co<=alu_co, z<=alu_z, neg<=alu_neg. pc<=pc+1 (mod 2^PC_W), then FETCH.
  - CLR: co, z, neg <= 0; acc unchanged; pc+1.
  - JMP: pc<=pc+off. off==0 means halt: go to HALT with pc unchanged.
  - BRZ: if z, pc<=pc+off, else pc+1.
  - BRN: if neg, pc<=pc+off, else pc+1.
  - Branches use the registered flags, never alu_z/alu_neg, and leave the flags unchanged. A taken branch with off==0 on BRZ/BRN is a normal self-loop, not a halt.
  - MLD, MST, LDR, STR: go to MEM without changing pc.
- MEM:
  - dm_req=1. dm_addr is imm for MLD/MST and REG_BASE+imm for LDR/STR. dm_we=1 for MST/STR; dm_wdata=acc.
  - On dm_ack: for reads, drive alu_op=kLDR/kMLD with alu_in_a=dm_rdata, then latch acc<=alu_acc and z<=alu_z. co and neg are unchanged; writes change no flags.
  - After dm_ack: pc+1, go to FETCH, dm_req=0 in the next cycle.
  - A wait counter increments each MEM cycle without ack. At MAX_WAIT cycles: err=1, dm_req=0, go to HALT.
- Latency: ALU/branch instruction = 2 cycles with a zero-wait ROM. Memory instruction = 3 cycles + dm wait cycles.
- Wrap-around: pc arithmetic is modulo 2^PC_W; 255+1 -> 0, and 2 + (-4) -> 254.
- If dm_ack arrives in the same cycle as the timeout limit, the ack wins: the access completes and err is not set.

Decomposition:
- Package definitions (existing): op_mne enum (kADD..kCLR) shared with alu; add state_t {IDLE, FETCH, EXEC, MEM, HALT}, the instruction field constants (OPC_MSB=8, OPC_LSB=5, OPD_W=5), and REG_BASE default.
- One sub-module: seq_pc, holding the pc register with next-pc mux (hold, +1, +off, clear). The FSM, ir, acc and flags stay in acc_sequencer.

Test Plan:
- Reset, start, ROM {LDI 5, ADD 3, JMP 0} -> acc_q=8, flags=3'b000, done=1 after 6 cycles, pc=2.
- Carry chain: LDI 31, SHL 3 (acc=248), ADD 8 -> acc=0, co=1, z=1. Next ADD 0 uses ci=1 -> acc=1, co=0, z=0.
- Branches: z=1, BRZ off=-2 at pc=2 -> pc=0. z=0 -> pc=3. BRN at pc=0 with off=-1, neg=1 -> pc=255.
- Memory: MST 4 with acc=8'hA5 and a 3-cycle ack delay -> dm_req high 4 cycles, dm_we=1, dm_addr=4, dm_wdata=A5. Then LDR 2 returns 8'h00 -> dm_addr=E2, acc=0, z=1.
- Timeout and async reset: dm_ack never asserted -> err=1 and done=1 after MAX_WAIT=15 MEM cycles. Separately, reset asserted mid-MEM -> dm_req=0 with no clock edge, all outputs at reset values.
- start pulses while busy -> ignored (state trace unchanged). start in HALT -> refetch from pc=0 with acc preserved.
